// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM encodings, default widths and count-width helper for the ALU side units
package alu_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_CHUNK_W = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/chunk_popcount.sv
// chunk_popcount: combinational count of set bits in one W-bit chunk
module chunk_popcount #(
  parameter int W = 8,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_bits,
  output logic [CW-1:0] o_count
);
  // ripple sum of the individual bits; W is small so a linear adder chain is fine
  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++) o_count = o_count + CW'(i_bits[i]);
  end
endmodule

// File: rtl/xnor_match_counter.sv
// xnor_match_counter: multi-cycle Hamming-similarity count of ~(A^B), CHUNK_W bits per cycle
module xnor_match_counter
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CHUNK_W = DEF_CHUNK_W,
  parameter int CNT_W = cnt_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  match_count,
  output logic              all_equal
);
  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PC_W = $clog2(CHUNK_W + 1);
  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [DATA_W-1:0]  r_x;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_match;
  logic               r_all;
  logic [CNT_W-1:0]   w_sum;
  logic [CHUNK_W-1:0] w_chunk;
  logic [PC_W-1:0]    w_pc;
  logic               w_last;
  assign w_chunk = r_x[int'(r_idx) * CHUNK_W +: CHUNK_W];
  assign w_last = r_idx == IDX_W'(NCHUNK - 1);
  assign w_sum = r_acc + CNT_W'(w_pc);
  assign match_count = r_match;
  assign all_equal = r_all;
  chunk_popcount #(.W(CHUNK_W)) u_pop (
    .i_bits (w_chunk),
    .o_count(w_pc)
  );
  // state register; reset aborts any running or pending operation
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  // next state: accept in IDLE, leave COUNT after the last chunk, release DONE on handshake
  always_comb begin
    w_next = (r_state == ST_IDLE)  ? (in_valid ? ST_COUNT : ST_IDLE) :
             (r_state == ST_COUNT) ? (w_last ? ST_DONE : ST_COUNT) :
             (r_state == ST_DONE)  ? (out_ready ? ST_IDLE : ST_DONE) : ST_IDLE;
  end
  // handshake outputs decoded from state alone
  always_comb begin
    in_ready = r_state == ST_IDLE;
    out_valid = r_state == ST_DONE;
  end
  // datapath: latch the XNOR on accept, accumulate one chunk per COUNT cycle, publish on the last
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_idx <= '0;
      r_acc <= '0;
      r_match <= '0;
      r_all <= 1'b0;
    end else if (r_state == ST_IDLE && in_valid) begin
      r_x <= ~(A ^ B);
      r_idx <= '0;
      r_acc <= '0;
    end else if (r_state == ST_COUNT) begin
      r_acc <= w_sum;
      r_idx <= w_last ? r_idx : r_idx + 1'b1;
      if (w_last) begin
        r_match <= w_sum;
        r_all <= w_sum == CNT_W'(DATA_W);
      end
    end
  end
endmodule

// File: tb/tb_xnor_match_counter.sv
// tb_xnor_match_counter: table vectors, corner sequences and random ops against a scoreboard
module tb_xnor_match_counter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic        in_ready;
  logic        out_valid;
  logic [6:0]  match_count;
  logic        all_equal;
  typedef struct packed {logic [6:0] cnt; logic eq;} exp_t;
  typedef struct {logic [63:0] a; logic [63:0] b; logic [6:0] cnt; logic eq;} vec_t;
  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_acc = 0;
  int n_res = 0;
  xnor_match_counter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .match_count(match_count), .all_equal(all_equal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.cnt = 7'($countones(~(a ^ b)));
    e.eq = e.cnt == 7'd64;
    return e;
  endfunction
  task automatic tick();
    exp_t e;
    if (rst) begin
      n_acc -= q.size();
      q.delete();
    end else begin
      if (in_valid && in_ready) begin
        q.push_back(model(A, B));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got count %0d, expected no result", match_count);
        end else begin
          e = q.pop_front();
          chk("sb_match_count", 64'(match_count), 64'(e.cnt));
          chk("sb_all_equal", 64'(all_equal), 64'(e.eq));
          n_res++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, output int lat);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    A = a;
    B = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL op_timeout: got no out_valid after %0d cycles, expected 9", lat);
    end else tick();
  endtask
  initial begin
    vec_t vt[7];
    int lat;
    int c;
    int r0;
    logic [6:0] mc0;
    vt[0] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 7'd64, 1'b1};
    vt[1] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 7'd0, 1'b0};
    vt[2] = '{64'h0, 64'h1, 7'd63, 1'b0};
    vt[3] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 7'd0, 1'b0};
    vt[4] = '{64'hFF00_0000_0000_0000, 64'h0, 7'd56, 1'b0};
    vt[5] = '{64'h8000_0000_0000_0001, 64'h0, 7'd62, 1'b0};
    vt[6] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F1F0_F0F0_F0F0, 7'd63, 1'b0};
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_match_count", 64'(match_count), 64'd0);
    chk("rst_all_equal", 64'(all_equal), 64'd0);
    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].a, vt[i].b, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
      chk($sformatf("vec%0d_count", i), 64'(match_count), 64'(vt[i].cnt));
      chk($sformatf("vec%0d_all_equal", i), 64'(all_equal), 64'(vt[i].eq));
    end
    out_ready = 1'b0;
    A = 64'h0000_FFFF_0000_FFFF;
    B = 64'h0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 40) begin
      tick();
      c++;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    mc0 = match_count;
    chk("bp_count", 64'(mc0), 64'd32);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_hold_count", 64'(match_count), 64'(mc0));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 12; k++) tick();
    A = 64'h0;
    B = 64'h00FF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      chk("cnt_in_ready_low", 64'(in_ready), 64'd0);
      chk("cnt_out_valid_low", 64'(out_valid), 64'd0);
      tick();
    end
    chk("chg_out_valid", 64'(out_valid), 64'd1);
    tick();
    chk("chg_count", 64'(match_count), 64'd56);
    A = 64'h0;
    B = 64'hFFFF_FFFF_FFFF_FFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_match_count", 64'(match_count), 64'd0);
    run_op(64'h0, 64'h0, lat);
    chk("abort_new_count", 64'(match_count), 64'd64);
    chk("abort_new_all_equal", 64'(all_equal), 64'd1);
    r0 = n_res;
    c = 0;
    while (n_res - r0 < 1000 && c < 60000) begin
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      A = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: B = A;
        1: B = ~A;
        2: B = A ^ (64'h1 << $urandom_range(0, 63));
        default: B = {$urandom, $urandom};
      endcase
      tick();
      c++;
    end
    chk("rand_ops_done", 64'(n_res - r0 >= 1000), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (q.size() != 0 && c < 40) begin
      tick();
      c++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("results_vs_accepts", 64'(n_res), 64'(n_acc));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
